ntt_seq_ctrl: RTL and testbench

- Sequencer for forward NTT on one 256-coefficient polynomial held in a 32-word x 96-bit (8 coeff) RAM.
- Sits directly upstream of the butterfly processor. Drives RAM read addresses, twiddle-ROM addresses and the processor's op_mode/stage/type controls.
- Issues write-back addresses aligned to the processor's output latency.
- Datapath is external: RAM rdata feeds processor in_data, ROM data feeds in_coef, and processor out_data feeds RAM wdata. This block is control and address only.

---
 rtl/ntt_pkg.sv | 36 +++
 rtl/ntt_seq_ctrl_if.sv | 27 ++
 rtl/ntt_wb_delay.sv | 25 ++
 rtl/ntt_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_ntt_seq_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and address helpers for the NTT sequencer.
package ntt_pkg;

    localparam logic [1:0] OP_NTT    = 2'd0;
    localparam logic [1:0] OP_INVNTT = 2'd1;
    localparam logic [1:0] OP_MULT   = 2'd2;
    localparam logic [1:0] OP_ADDSUB = 2'd3;

    localparam int unsigned N_WORDS  = 32;
    localparam int unsigned N_STAGES = 7;
    localparam int unsigned Q        = 3329;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    // Low word of butterfly pair p in inter-word stage (0..4).
    function automatic logic [4:0] pair_lo(input logic [2:0] stage, input logic [3:0] p);
        logic [2:0] h;
        logic [4:0] p5;
        logic [4:0] mask;
        h    = 3'd4 - stage;
        p5   = {1'b0, p};
        mask = (5'd1 << h) - 5'd1;
        return ((p5 >> h) << (h + 3'd1)) | (p5 & mask);
    endfunction

    function automatic logic [4:0] pair_span(input logic [2:0] stage);
        return 5'd16 >> stage;
    endfunction

    function automatic logic [6:0] tw_index(input logic [2:0] stage, input logic [3:0] p);
        logic [2:0] h;
        h = 3'd4 - stage;
        return (7'd1 << stage) + ({3'b000, p} >> h);
    endfunction

endpackage

// File: rtl/ntt_seq_ctrl_if.sv
// Control/address bundle between the NTT sequencer and RAM, twiddle ROM and butterfly.
interface ntt_seq_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       ram_ren;
    logic [4:0] ram_raddr;
    logic       ram_wen;
    logic [4:0] ram_waddr;
    logic       tw_ren;
    logic [6:0] tw_addr;
    logic [1:0] bu_op_mode;
    logic [2:0] bu_stage;
    logic       bu_type;

    modport master (
        input  start,
        output busy, done, ram_ren, ram_raddr, ram_wen, ram_waddr,
        output tw_ren, tw_addr, bu_op_mode, bu_stage, bu_type
    );

    modport slave (
        output start,
        input  busy, done, ram_ren, ram_raddr, ram_wen, ram_waddr,
        input  tw_ren, tw_addr, bu_op_mode, bu_stage, bu_type
    );
endinterface

// File: rtl/ntt_wb_delay.sv
// Fixed-depth shift register carrying {valid, addr} from read issue to write-back.
module ntt_wb_delay #(
    parameter int unsigned DEPTH = 7,
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_bits,
    output logic [WIDTH-1:0] out_bits
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= in_bits;
            for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign out_bits = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_seq_ctrl.sv
// Forward-NTT sequencer: issues RAM/twiddle reads per stage and in-place write-back addresses.
module ntt_seq_ctrl
    import ntt_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 6,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    ntt_seq_ctrl_if.master     bus
);

    localparam int unsigned WB_DEPTH = RD_LAT + PIPE_LAT;
    localparam int unsigned CW       = $clog2(WB_DEPTH + 1);

    state_e        state_q, state_d;
    logic [2:0]    stage_q, stage_d;
    logic [4:0]    k_q, k_d;
    logic [CW-1:0] drain_q, drain_d;

    logic          ren_q, ren_d;
    logic [4:0]    raddr_q, raddr_d;
    logic          tw_ren_q, tw_ren_d;
    logic [6:0]    tw_addr_q, tw_addr_d;
    logic [2:0]    bu_stage_q;
    logic          bu_type_q;
    logic [4:0]    lo;
    logic [5:0]    wb_out;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StIssue;
                    stage_d = 3'd0;
                    k_d     = 5'd0;
                end
            end
            StIssue: begin
                k_d = k_q + 5'd1;
                if (k_q == 5'(N_WORDS - 1)) begin
                    state_d = StDrain;
                    drain_d = CW'(WB_DEPTH);
                end
            end
            StDrain: begin
                // Counter runs WB_DEPTH..1, so the last write of the stage lands before
                // the first read of the next one.
                drain_d = drain_q - CW'(1);
                if (drain_q == CW'(1)) begin
                    if (stage_q == 3'(N_STAGES - 1)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                        stage_d = stage_q + 3'd1;
                        k_d     = 5'd0;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Read/twiddle outputs are computed from the next state so they register on the
    // same edge the FSM enters the corresponding issue slot.
    always_comb begin
        ren_d     = 1'b0;
        tw_ren_d  = 1'b0;
        raddr_d   = raddr_q;
        tw_addr_d = tw_addr_q;
        lo        = '0;
        if (state_d == StIssue) begin
            ren_d = 1'b1;
            if (stage_d < 3'd5) begin
                lo      = pair_lo(stage_d, k_d[4:1]);
                raddr_d = k_d[0] ? lo + pair_span(stage_d) : lo;
                if (!k_d[0]) begin
                    tw_ren_d  = 1'b1;
                    tw_addr_d = tw_index(stage_d, k_d[4:1]);
                end
            end else if (stage_d == 3'd5) begin
                raddr_d   = k_d;
                tw_ren_d  = 1'b1;
                tw_addr_d = 7'd32 + {2'b00, k_d};
            end else begin
                raddr_d   = k_d;
                tw_ren_d  = 1'b1;
                tw_addr_d = 7'd64 + {1'b0, k_d, 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            stage_q    <= '0;
            k_q        <= '0;
            drain_q    <= '0;
            ren_q      <= 1'b0;
            raddr_q    <= '0;
            tw_ren_q   <= 1'b0;
            tw_addr_q  <= '0;
            bu_stage_q <= '0;
            bu_type_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            k_q       <= k_d;
            drain_q   <= drain_d;
            ren_q     <= ren_d;
            raddr_q   <= raddr_d;
            tw_ren_q  <= tw_ren_d;
            tw_addr_q <= tw_addr_d;
            // Controls trail the read by one cycle to meet rdata (RD_LAT is 1).
            if (state_q == StIssue) bu_stage_q <= stage_q;
            bu_type_q <= (state_q == StIssue) && (stage_q < 3'd5) && k_q[0];
        end
    end

    ntt_wb_delay #(
        .DEPTH (WB_DEPTH),
        .WIDTH (6)
    ) u_wb_delay (
        .clk      (clk),
        .rst      (rst),
        .in_bits  ({ren_q, raddr_q}),
        .out_bits (wb_out)
    );

    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.ram_ren    = ren_q;
    assign bus.ram_raddr  = raddr_q;
    assign bus.ram_wen    = wb_out[5];
    assign bus.ram_waddr  = wb_out[4:0];
    assign bus.tw_ren     = tw_ren_q;
    assign bus.tw_addr    = tw_addr_q;
    assign bus.bu_op_mode = OP_NTT;
    assign bus.bu_stage   = bu_stage_q;
    assign bus.bu_type    = bu_type_q;

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Self-checking bench for ntt_seq_ctrl: per-cycle model compare plus pinned literal values.
module tb_ntt_seq_ctrl;

    localparam int LAT       = 7;   // RD_LAT + PIPE_LAT
    localparam int STAGE_LEN = 39;  // 32 issue + 7 drain
    localparam int DONE_OFF  = 274;
    localparam int MAXOFF    = 320;
    localparam int RUN_CYC   = 300;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_seq_ctrl_if bus ();

    ntt_seq_ctrl #(
        .PIPE_LAT (6),
        .RD_LAT   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit exp_ren   [MAXOFF];
    bit exp_wen   [MAXOFF];
    bit exp_twren [MAXOFF];
    int exp_raddr [MAXOFF];
    int exp_waddr [MAXOFF];
    int exp_tw    [MAXOFF];
    int exp_type  [MAXOFF];
    int exp_stage [MAXOFF];
    int got_raddr [MAXOFF];
    int got_waddr [MAXOFF];
    int got_tw    [MAXOFF];

    bit active   = 1'b0;
    bit aborting = 1'b0;
    int c0, abort_off;
    int wen_count, done_count, done_off, wen_after_abort;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"},    int'(bus.busy), 0);
        chk({pfx, "_done"},    int'(bus.done), 0);
        chk({pfx, "_ren"},     int'(bus.ram_ren), 0);
        chk({pfx, "_raddr"},   int'(bus.ram_raddr), 0);
        chk({pfx, "_wen"},     int'(bus.ram_wen), 0);
        chk({pfx, "_waddr"},   int'(bus.ram_waddr), 0);
        chk({pfx, "_tw_ren"},  int'(bus.tw_ren), 0);
        chk({pfx, "_tw_addr"}, int'(bus.tw_addr), 0);
        chk({pfx, "_op_mode"}, int'(bus.bu_op_mode), 0);
        chk({pfx, "_stage"},   int'(bus.bu_stage), 0);
        chk({pfx, "_type"},    int'(bus.bu_type), 0);
    endtask

    // Model: cycle offsets relative to the start cycle c0, built from the addressing rules.
    initial begin
        for (int i = 0; i < MAXOFF; i++) begin
            exp_ren[i] = 0; exp_wen[i] = 0; exp_twren[i] = 0;
            exp_raddr[i] = 0; exp_waddr[i] = 0; exp_tw[i] = 0;
            exp_type[i] = 0; exp_stage[i] = 0;
        end
        for (int s = 0; s < 7; s++) begin
            for (int k = 0; k < 32; k++) begin
                int off, p, h, lo, addr, tw, typ, twr;
                off = 1 + s * STAGE_LEN + k;
                p   = k / 2;
                if (s < 5) begin
                    h    = 4 - s;
                    lo   = ((p >> h) << (h + 1)) | (p & ((1 << h) - 1));
                    addr = (k % 2 == 1) ? lo + (16 >> s) : lo;
                    tw   = (1 << s) + (p >> h);
                    typ  = k % 2;
                    twr  = (k % 2 == 0);
                end else if (s == 5) begin
                    addr = k; tw = 32 + k; typ = 0; twr = 1;
                end else begin
                    addr = k; tw = 64 + 2 * k; typ = 0; twr = 1;
                end
                exp_ren[off]       = 1;
                exp_raddr[off]     = addr;
                exp_tw[off]        = tw;
                exp_twren[off]     = twr[0];
                exp_type[off]      = typ;
                exp_stage[off]     = s;
                exp_wen[off + LAT]   = 1;
                exp_waddr[off + LAT] = addr;
            end
        end
    end

    always @(negedge clk) begin
        int off;
        if (active) begin
            off = cyc - c0;
            if (off >= 0 && off < MAXOFF) begin
                got_raddr[off] = bus.ram_raddr;
                got_waddr[off] = bus.ram_waddr;
                got_tw[off]    = bus.tw_addr;
                if (aborting && off > abort_off) begin
                    chk_zero("abort");
                    if (bus.ram_wen) wen_after_abort++;
                end else begin
                    chk("busy",    int'(bus.busy), int'(off >= 1 && off <= DONE_OFF));
                    chk("done",    int'(bus.done), int'(off == DONE_OFF));
                    chk("ram_ren", int'(bus.ram_ren), int'(exp_ren[off]));
                    chk("tw_ren",  int'(bus.tw_ren), int'(exp_twren[off]));
                    chk("ram_wen", int'(bus.ram_wen), int'(exp_wen[off]));
                    if (bus.busy) chk("op_mode", int'(bus.bu_op_mode), 0);
                    if (exp_ren[off]) begin
                        chk("ram_raddr", int'(bus.ram_raddr), exp_raddr[off]);
                        chk("tw_addr",   int'(bus.tw_addr), exp_tw[off]);
                    end
                    if (exp_wen[off]) chk("ram_waddr", int'(bus.ram_waddr), exp_waddr[off]);
                    if (off >= 1 && exp_ren[off - 1]) begin
                        chk("bu_stage", int'(bus.bu_stage), exp_stage[off - 1]);
                        chk("bu_type",  int'(bus.bu_type), exp_type[off - 1]);
                    end
                    chk("rw_collision", int'(bus.ram_ren && bus.ram_wen &&
                                             bus.ram_raddr == bus.ram_waddr), 0);
                end
                if (bus.ram_wen) wen_count++;
                if (bus.done) begin
                    done_count++;
                    done_off = off;
                end
            end
        end
    end

    task automatic run(input bit abort_it, input bit extra_start);
        wen_count       = 0;
        done_count      = 0;
        done_off        = -1;
        wen_after_abort = 0;
        aborting        = abort_it;
        abort_off       = 1 + 2 * STAGE_LEN + 5;  // inside stage 2 issue
        @(posedge clk); #1;
        bus.start = 1'b1;
        c0        = cyc;
        active    = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i < RUN_CYC; i++) begin
            bus.start = (extra_start && i == 50);
            rst       = (abort_it && i == abort_off);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        rst       = 1'b0;
        active    = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        rst       = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Run A, with an ignored start pulse mid-run.
        run(1'b0, 1'b1);
        chk("pin_s0_k0_raddr",  got_raddr[1], 0);
        chk("pin_s0_k1_raddr",  got_raddr[2], 16);
        chk("pin_s0_k31_raddr", got_raddr[32], 31);
        chk("pin_s0_tw",        got_tw[17], 1);
        chk("pin_s1_p8_lo",     got_raddr[56], 16);
        chk("pin_s1_p8_hi",     got_raddr[57], 24);
        chk("pin_s1_p8_tw",     got_tw[56], 3);
        chk("pin_s4_k1_raddr",  got_raddr[158], 1);
        chk("pin_s4_k0_tw",     got_tw[157], 16);
        chk("pin_s4_k31_tw",    got_tw[188], 31);
        chk("pin_s5_k0_tw",     got_tw[196], 32);
        chk("pin_s6_k31_tw",    got_tw[266], 126);
        chk("pin_wb_first",     got_waddr[8], 0);
        chk("pin_wb_second",    got_waddr[9], 16);
        chk("wen_total_a",      wen_count, 224);
        chk("done_count_a",     done_count, 1);
        chk("done_cycle_a",     done_off, DONE_OFF);

        // Run B: a second start after done repeats the same sequence.
        run(1'b0, 1'b0);
        chk("wen_total_b",  wen_count, 224);
        chk("done_count_b", done_count, 1);
        chk("done_cycle_b", done_off, DONE_OFF);

        // Run C: reset during stage 2 aborts with no further writes and no done.
        run(1'b1, 1'b0);
        chk("abort_wen_after", wen_after_abort, 0);
        chk("abort_done",      done_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
